// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - access-mode constants, FSM encoding and fault rule for dmem_responder
package dmem_pkg;

  localparam logic [1:0] ACC_WORD = 2'b00;
  localparam logic [1:0] ACC_HALF = 2'b01;
  localparam logic [1:0] ACC_BYTE = 2'b10;
  localparam logic [1:0] ACC_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Misaligned, reserved-size or simultaneous read+write requests are rejected.
  function automatic logic acc_fault(input logic rd, input logic wr,
                                     input logic [1:0] mode, input logic [1:0] off);
    logic bad;
    bad = rd && wr;
    case (mode)
      ACC_WORD: bad = bad || (off != 2'b00);
      ACC_HALF: bad = bad || off[0];
      ACC_BYTE: bad = bad;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port 4-lane byte-enable synchronous RAM
module dmem_ram #(
  parameter int WORDS_W   = 10,
  parameter     INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [WORDS_W-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [2**WORDS_W];

  // Read port holds its last value while en is low, so the word survives WAIT.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder: FSM, lane steering, fault checks
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_acc_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        fault
);

  localparam int WORDS_W = ADDR_W - 2;

  state_t              state, state_nx;
  logic [3:0]          cnt;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                write_q;
  logic                fault_q;

  logic                req;
  logic                ram_en;
  logic                ram_we;
  logic [3:0]          ram_be;
  logic [WORDS_W-1:0]  ram_addr;
  logic [31:0]         ram_wdata;
  logic [31:0]         ram_rdata;
  logic [31:0]         shifted;
  logic [31:0]         lane_rdata;
  logic                unused_addr_bits;

  assign req              = req_read | req_write;
  assign unused_addr_bits = ^req_addr[31:ADDR_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 4'd0;
      mode_q  <= ACC_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && req) begin
        cnt     <= 4'(WAIT_STATES);
        mode_q  <= req_acc_mode;
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        write_q <= req_write;
        fault_q <= acc_fault(req_read, req_write, req_acc_mode, req_addr[1:0]);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (req) state_nx = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
        else     state_nx = ST_IDLE;
      end
      ST_WAIT: state_nx = (cnt <= 4'd1) ? ST_DONE : ST_WAIT;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    shifted = ram_rdata >> {addr_q[1:0], 3'b000};
    case (mode_q)
      ACC_HALF: lane_rdata = {16'h0000, shifted[15:0]};
      ACC_BYTE: lane_rdata = {24'h000000, shifted[7:0]};
      default:  lane_rdata = shifted;
    endcase
  end

  // Narrow stores replicate the data across lanes; the byte enables pick the target.
  always_comb begin
    case (mode_q)
      ACC_BYTE: begin
        ram_wdata = {4{wdata_q[7:0]}};
        ram_be    = 4'b0001 << addr_q[1:0];
      end
      ACC_HALF: begin
        ram_wdata = {2{wdata_q[15:0]}};
        ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        ram_wdata = wdata_q;
        ram_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    rvalid = 1'b0;
    fault  = 1'b0;
    rdata  = 32'h0;
    ram_we = 1'b0;
    case (state)
      ST_IDLE: stall = req;
      ST_WAIT: stall = 1'b1;
      ST_DONE: begin
        fault  = fault_q;
        rvalid = !fault_q && !write_q;
        ram_we = write_q && !fault_q;
        if (!fault_q && !write_q) rdata = lane_rdata;
      end
      default: stall = 1'b0;
    endcase
    ram_en = (state == ST_IDLE && req) || ram_we;
  end

  assign ram_addr = (state == ST_DONE) ? addr_q[ADDR_W-1:2] : req_addr[ADDR_W-1:2];

  dmem_ram #(
    .WORDS_W  (WORDS_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (ram_be),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (WAIT_STATES=1 and 0 instances)
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct packed {
    logic        flt;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_read     [2];
  logic        req_write    [2];
  logic [1:0]  req_acc_mode [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        stall        [2];
  logic [31:0] rdata        [2];
  logic        rvalid       [2];
  logic        fault        [2];

  logic [7:0]  mem_m [2][4096];
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      dmem_responder #(
        .ADDR_W     (12),
        .WAIT_STATES((g == 0) ? 1 : 0),
        .INIT_FILE  ("")
      ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_read    (req_read[g]),
        .req_write   (req_write[g]),
        .req_acc_mode(req_acc_mode[g]),
        .req_addr    (req_addr[g]),
        .req_wdata   (req_wdata[g]),
        .stall       (stall[g]),
        .rdata       (rdata[g]),
        .rvalid      (rvalid[g]),
        .fault       (fault[g])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_fault(input logic rd, input logic wr,
                                       input logic [1:0] mode, input logic [31:0] addr);
    if (rd && wr) return 1'b1;
    if (mode == 2'b11) return 1'b1;
    if (mode == 2'b00) return (addr % 4) != 0;
    if (mode == 2'b01) return (addr % 2) != 0;
    return 1'b0;
  endfunction

  function automatic int model_size(input logic [1:0] mode);
    return (mode == 2'b00) ? 4 : (mode == 2'b01) ? 2 : 1;
  endfunction

  task automatic clear_inputs(input int d);
    req_read[d]     = 1'b0;
    req_write[d]    = 1'b0;
    req_acc_mode[d] = 2'b00;
    req_addr[d]     = 32'h0;
    req_wdata[d]    = 32'h0;
  endtask

  // Issue one access from a posedge+#1 point and return at posedge+#1 after DONE.
  task automatic access(input int d, input logic rd, input logic wr, input logic [1:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   nb, n, st, ws, idx;
    logic flt;
    ws    = (d == 0) ? 1 : 0;
    flt   = model_fault(rd, wr, mode, addr);
    nb    = model_size(mode);
    e.flt = flt;
    e.data = 32'h0;
    if (!flt && rd) begin
      for (int i = 0; i < nb; i++) begin
        idx = int'((addr + 32'(i)) % 4096);
        e.data[8*i +: 8] = mem_m[d][idx];
      end
    end else if (!flt) begin
      for (int i = 0; i < nb; i++) begin
        idx = int'((addr + 32'(i)) % 4096);
        mem_m[d][idx] = wdata[8*i +: 8];
      end
    end
    if (flt || rd) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    req_read[d]     = rd;
    req_write[d]    = wr;
    req_acc_mode[d] = mode;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    n  = 0;
    st = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (stall[d]) st++;
      else break;
    end
    @(posedge clk);
    #1;
    clear_inputs(d);
    check($sformatf("d%0d_cycles@%h", d, addr), 32'(n), 32'(ws + 2));
    check($sformatf("d%0d_stalled@%h", d, addr), 32'(st), 32'(ws + 1));
  endtask

  task automatic reset_mid_write();
    req_write[0]    = 1'b1;
    req_acc_mode[0] = ACC_WORD;
    req_addr[0]     = 32'h20;
    req_wdata[0]    = 32'h12345678;
    @(posedge clk);
    #1;
    check("rst_wait_stall", 32'(stall[0]), 32'd1);
    reset_n = 1'b0;
    clear_inputs(0);
    #1;
    check("rst_stall_drop", 32'(stall[0]), 32'd0);
    check("rst_fault", 32'(fault[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset_n && (rvalid[d] || fault[d])) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL d%0d_unexpected_resp: got rvalid=%0b fault=%0b rdata=%h expected none",
                   d, rvalid[d], fault[d], rdata[d]);
        end else begin
          mon_e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("d%0d_fault", d), 32'(fault[d]), 32'(mon_e.flt));
          check($sformatf("d%0d_rvalid", d), 32'(rvalid[d]), 32'(!mon_e.flt));
          check($sformatf("d%0d_rdata", d), rdata[d], mon_e.data);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, w;
    logic [1:0]  m;
    logic        rd, wr;
    int          d, r;

    reset_n = 1'b0;
    clear_inputs(0);
    clear_inputs(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d_rst_stall", k), 32'(stall[k]), 32'd0);
      check($sformatf("d%0d_rst_rdata", k), rdata[k], 32'd0);
      check($sformatf("d%0d_rst_rvalid", k), 32'(rvalid[k]), 32'd0);
      check($sformatf("d%0d_rst_fault", k), 32'(fault[k]), 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) access(k, 1'b0, 1'b1, ACC_WORD, 32'(i * 4), $urandom);

    access(0, 1'b0, 1'b1, ACC_WORD, 32'h10, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, ACC_WORD, 32'h10, 32'h0);
    access(0, 1'b0, 1'b1, ACC_BYTE, 32'h13, 32'h0000005A);
    access(0, 1'b1, 1'b0, ACC_WORD, 32'h10, 32'h0);
    access(0, 1'b1, 1'b0, ACC_HALF, 32'h12, 32'h0);
    access(0, 1'b1, 1'b0, ACC_BYTE, 32'h11, 32'h0);
    access(0, 1'b1, 1'b0, ACC_HALF, 32'h11, 32'h0);
    access(0, 1'b0, 1'b1, ACC_WORD, 32'h12, 32'hFFFFFFFF);
    access(0, 1'b1, 1'b0, ACC_WORD, 32'h10, 32'h0);
    access(0, 1'b1, 1'b1, ACC_WORD, 32'h18, 32'hFFFFFFFF);
    access(0, 1'b1, 1'b0, ACC_RSVD, 32'h18, 32'h0);

    reset_mid_write();
    access(0, 1'b1, 1'b0, ACC_WORD, 32'h20, 32'h0);

    access(0, 1'b0, 1'b1, ACC_WORD, 32'h1004, 32'hCAFEF00D);
    access(0, 1'b1, 1'b0, ACC_WORD, 32'h0004, 32'h0);

    access(1, 1'b0, 1'b1, ACC_WORD, 32'h14, 32'h87654321);
    access(1, 1'b1, 1'b0, ACC_WORD, 32'h10, 32'h0);
    access(1, 1'b1, 1'b0, ACC_WORD, 32'h14, 32'h0);

    for (int t = 0; t < 300; t++) begin
      d  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 15));
      rd = (r == 0) || (r < 8);
      wr = (r == 0) || (r >= 8);
      m  = 2'($urandom_range(0, 3));
      a  = $urandom & 32'hFFFF_F03F;
      if ($urandom_range(0, 3) != 0) begin
        if (m == ACC_WORD) a = a & ~32'h3;
        if (m == ACC_HALF) a = a & ~32'h1;
      end
      w = $urandom;
      access(d, rd, wr, m, a, w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
